// File: rtl/sram_array_2p_ext.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_2p_ext
// Summary  : Behavioural 1R1W segment-masked SRAM with selectable read latency,
//            read-during-write bypass and a clear-on-reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module sram_array_2p_ext #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int SEGS       = 16,
    parameter int SEG_W      = 132,
    parameter int READ_LAT   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  R0_en,
    input  logic [ADDR_W-1:0]     R0_addr,
    output logic                  R0_valid,
    output logic [SEGS*SEG_W-1:0] R0_data,
    input  logic                  W0_en,
    input  logic [ADDR_W-1:0]     W0_addr,
    input  logic [SEGS-1:0]       W0_mask,
    input  logic [SEGS*SEG_W-1:0] W0_data
);
    localparam int              c_W     = SEGS * SEG_W;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LAST  = (ADDR_W+1)'(DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_READY = 2'd2;

    logic [1:0]     r_state;
    logic [ADDR_W:0] r_cnt;
    logic [c_W-1:0] r_mem [DEPTH];
    logic           r_v1;
    logic [c_W-1:0] r_d1;

    logic           w_rd_acc;
    logic           w_wr_acc;
    logic           w_rd_in_range;
    logic           w_bypass_hit;
    logic [c_W-1:0] w_rd_word;

    assign init_done     = (r_state == c_ST_READY);
    assign w_rd_in_range = ({1'b0, R0_addr} < c_DEPTH);
    assign w_rd_acc      = init_done & R0_en;
    assign w_wr_acc      = init_done & W0_en & ({1'b0, W0_addr} < c_DEPTH);
    assign w_bypass_hit  = (BYPASS != 0) && w_wr_acc && (W0_addr == R0_addr);

    // Counter is one bit wider than the address so DEPTH == 2**ADDR_W cannot alias.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= (INIT_CLEAR != 0) ? c_ST_CLEAR : c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE:  r_state <= c_ST_READY;
                c_ST_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_ST_READY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default:    r_state <= c_ST_READY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= '0;
            end else if (w_wr_acc) begin
                for (int i = 0; i < SEGS; i++) begin
                    if (W0_mask[i]) begin
                        r_mem[W0_addr][i*SEG_W +: SEG_W] <= W0_data[i*SEG_W +: SEG_W];
                    end
                end
            end
        end
    end

    // Same-address write segments override the stored word only when bypassing.
    always_comb begin
        w_rd_word = w_rd_in_range ? r_mem[R0_addr] : '0;
        for (int i = 0; i < SEGS; i++) begin
            if (w_bypass_hit && W0_mask[i]) begin
                w_rd_word[i*SEG_W +: SEG_W] = W0_data[i*SEG_W +: SEG_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_d1 <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic           r_v2;
            logic [c_W-1:0] r_d2;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign R0_valid = r_v2;
            assign R0_data  = r_d2;
        end else begin : g_lat1
            assign R0_valid = r_v1;
            assign R0_data  = r_d1;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sram_array_2p_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_array_2p_ext
// Summary  : Directed bench driving four sram_array_2p_ext parameter sets from
//            one stimulus stream, checked against a per-instance memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_array_2p_ext;
    localparam int NI = 4;

    // Instance parameter sets: a=lat1/bypass, b=lat2/old-data, c=depth6, d=no clear
    int c_DEP [NI] = '{8, 8, 6, 8};
    int c_LAT [NI] = '{1, 2, 1, 1};
    int c_BYP [NI] = '{1, 0, 1, 1};
    int c_ICL [NI] = '{1, 1, 1, 0};

    logic        clock = 1'b0;
    logic        rst;
    logic        r_en;
    logic [2:0]  r_addr;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [3:0]  w_mask;
    logic [31:0] w_data;

    logic        ido [NI];
    logic        vld [NI];
    logic [31:0] dat [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sram_array_2p_ext #(.DEPTH(8), .ADDR_W(3), .SEGS(4), .SEG_W(8),
        .READ_LAT(1), .BYPASS(1), .INIT_CLEAR(1)) u_a (
        .clock(clock), .reset(rst), .init_done(ido[0]),
        .R0_en(r_en), .R0_addr(r_addr), .R0_valid(vld[0]), .R0_data(dat[0]),
        .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data));

    sram_array_2p_ext #(.DEPTH(8), .ADDR_W(3), .SEGS(4), .SEG_W(8),
        .READ_LAT(2), .BYPASS(0), .INIT_CLEAR(1)) u_b (
        .clock(clock), .reset(rst), .init_done(ido[1]),
        .R0_en(r_en), .R0_addr(r_addr), .R0_valid(vld[1]), .R0_data(dat[1]),
        .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data));

    sram_array_2p_ext #(.DEPTH(6), .ADDR_W(3), .SEGS(4), .SEG_W(8),
        .READ_LAT(1), .BYPASS(1), .INIT_CLEAR(1)) u_c (
        .clock(clock), .reset(rst), .init_done(ido[2]),
        .R0_en(r_en), .R0_addr(r_addr), .R0_valid(vld[2]), .R0_data(dat[2]),
        .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data));

    sram_array_2p_ext #(.DEPTH(8), .ADDR_W(3), .SEGS(4), .SEG_W(8),
        .READ_LAT(1), .BYPASS(1), .INIT_CLEAR(0)) u_d (
        .clock(clock), .reset(rst), .init_done(ido[3]),
        .R0_en(r_en), .R0_addr(r_addr), .R0_valid(vld[3]), .R0_data(dat[3]),
        .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data));

    // ---------------- reference model ----------------
    logic [31:0] m_mem   [NI][8];
    int          m_since [NI];
    bit          m_v     [NI][2];
    logic [31:0] m_d     [NI][2];
    logic        exp_rdy [NI];
    logic        exp_v   [NI];
    logic [31:0] exp_d   [NI];
    bit          m_started = 1'b0;
    bit          t_rdy;
    bit          t_acc;
    logic [31:0] t_res;

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 8; a++) m_mem[k][a] = 'x;
            m_since[k] = 0;
            exp_rdy[k] = 1'b0;
            exp_v[k]   = 1'b0;
            exp_d[k]   = '0;
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_since[k] = 0;
                m_v[k][0]  = 1'b0;
                m_v[k][1]  = 1'b0;
                exp_rdy[k] = 1'b0;
                exp_v[k]   = 1'b0;
                exp_d[k]   = '0;
            end else begin
                t_rdy = exp_rdy[k];
                t_acc = t_rdy && r_en;
                t_res = '0;
                if (t_acc && int'(r_addr) < c_DEP[k]) begin
                    t_res = m_mem[k][r_addr];
                    if (c_BYP[k] != 0 && w_en && w_addr == r_addr)
                        for (int s = 0; s < 4; s++)
                            if (w_mask[s]) t_res[s*8 +: 8] = w_data[s*8 +: 8];
                end
                if (!t_rdy) begin
                    if (c_ICL[k] != 0 && m_since[k] < c_DEP[k])
                        m_mem[k][m_since[k][2:0]] = '0;
                end else if (w_en && int'(w_addr) < c_DEP[k]) begin
                    for (int s = 0; s < 4; s++)
                        if (w_mask[s]) m_mem[k][w_addr][s*8 +: 8] = w_data[s*8 +: 8];
                end
                if (m_since[k] < 1000) m_since[k]++;
                exp_rdy[k] = (c_ICL[k] != 0) ? (m_since[k] >= c_DEP[k]) : 1'b1;
                m_v[k][1] = m_v[k][0];
                m_d[k][1] = m_d[k][0];
                m_v[k][0] = t_acc;
                m_d[k][0] = t_res;
                exp_v[k]  = m_v[k][c_LAT[k]-1];
                if (exp_v[k]) exp_d[k] = m_d[k][c_LAT[k]-1];
            end
        end
        if (rst) m_started = 1'b1;
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_started) begin
            for (int k = 0; k < NI; k++) begin
                check("model_init_done", k, 32'(ido[k]), 32'(exp_rdy[k]));
                check("model_valid", k, 32'(vld[k]), 32'(exp_v[k]));
                if (!$isunknown(exp_d[k])) check("model_data", k, dat[k], exp_d[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int re, input int ra, input int we, input int wa,
                         input int wm, input logic [31:0] wd);
        r_en   = (re != 0);
        r_addr = 3'(ra);
        w_en   = (we != 0);
        w_addr = 3'(wa);
        w_mask = 4'(wm);
        w_data = wd;
        @(negedge clock);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_addr = '0; w_mask = '0; w_data = '0;
        @(negedge clock);
        idle();
        rst = 1'b0;

        // Clear sequence with accesses attempted midway
        for (int i = 0; i < 8; i++) begin
            drive(i == 5 ? 1 : 0, 2, i == 4 ? 1 : 0, 1, 4'hf, 32'hDEADBEEF);
            check("clear_init_done", 0, 32'(ido[0]), (i == 7) ? 32'd1 : 32'd0);
            check("clear_no_valid", 0, 32'(vld[0]), 32'd0);
        end
        for (int a = 0; a < 8; a++) begin
            drive(1, a, 0, 0, 0, 32'h0);
            check("clear_read_valid", 0, 32'(vld[0]), 32'd1);
            check("clear_read_zero", 0, dat[0], 32'h0);
        end
        idle();
        idle();

        // Masked write
        drive(0, 0, 1, 3, 4'hf, 32'hAAAAAAAA);
        drive(0, 0, 1, 3, 4'b0001, 32'h55555555);
        drive(1, 3, 0, 0, 0, 32'h0);
        check("mask_valid", 0, 32'(vld[0]), 32'd1);
        check("mask_data", 0, dat[0], 32'hAAAAAA55);
        idle();
        check("mask_data_lat2", 1, dat[1], 32'hAAAAAA55);
        check("mask_hold", 0, dat[0], 32'hAAAAAA55);

        // Read-during-write at the same address
        drive(0, 0, 1, 5, 4'hf, 32'h11223344);
        drive(1, 5, 1, 5, 4'b0011, 32'hCCDDEEFF);
        check("rdw_bypass_new", 0, dat[0], 32'h1122EEFF);
        drive(1, 5, 0, 0, 0, 32'h0);
        check("rdw_next_read", 0, dat[0], 32'h1122EEFF);
        check("rdw_nobypass_old", 1, dat[1], 32'h11223344);
        idle();
        check("rdw_nobypass_next", 1, dat[1], 32'h1122EEFF);

        // Out-of-range on the depth-6 instance
        drive(0, 0, 1, 7, 4'hf, 32'h99999999);
        drive(0, 0, 1, 6, 4'hf, 32'h99999999);
        drive(1, 7, 0, 0, 0, 32'h0);
        check("oor7_valid", 2, 32'(vld[2]), 32'd1);
        check("oor7_zero", 2, dat[2], 32'h0);
        check("inrange7_data", 0, dat[0], 32'h99999999);
        drive(1, 6, 0, 0, 0, 32'h0);
        check("oor6_valid", 2, 32'(vld[2]), 32'd1);
        check("oor6_zero", 2, dat[2], 32'h0);
        for (int a = 0; a < 6; a++) begin
            drive(1, a, 0, 0, 0, 32'h0);
            if (a == 3) check("oor_entry3_kept", 2, dat[2], 32'hAAAAAA55);
            if (a == 5) check("oor_entry5_kept", 2, dat[2], 32'h1122EEFF);
        end
        idle();

        // Latency and hold
        drive(0, 0, 1, 1, 4'hf, 32'h01010101);
        drive(0, 0, 1, 2, 4'hf, 32'h02020202);
        drive(0, 0, 1, 3, 4'hf, 32'h03030303);
        drive(1, 1, 0, 0, 0, 32'h0);
        check("lat1_r1_valid", 0, 32'(vld[0]), 32'd1);
        check("lat1_r1_data", 0, dat[0], 32'h01010101);
        check("lat2_r1_wait", 1, 32'(vld[1]), 32'd0);
        drive(1, 2, 0, 0, 0, 32'h0);
        check("lat1_r2_data", 0, dat[0], 32'h02020202);
        check("lat2_r1_valid", 1, 32'(vld[1]), 32'd1);
        check("lat2_r1_data", 1, dat[1], 32'h01010101);
        drive(1, 3, 0, 0, 0, 32'h0);
        check("lat1_r3_data", 0, dat[0], 32'h03030303);
        check("lat2_r2_data", 1, dat[1], 32'h02020202);
        idle();
        check("lat1_end_valid", 0, 32'(vld[0]), 32'd0);
        check("lat1_hold", 0, dat[0], 32'h03030303);
        check("lat2_r3_valid", 1, 32'(vld[1]), 32'd1);
        check("lat2_r3_data", 1, dat[1], 32'h03030303);
        idle();
        check("lat2_end_valid", 1, 32'(vld[1]), 32'd0);
        check("lat2_hold", 1, dat[1], 32'h03030303);

        // Read in flight when reset hits
        drive(1, 1, 0, 0, 0, 32'h0);
        rst = 1'b1;
        idle();
        check("rst_kills_pending", 1, 32'(vld[1]), 32'd0);
        check("rst_data_zero", 1, dat[1], 32'h0);
        check("rst_data_zero", 0, dat[0], 32'h0);
        rst = 1'b0;

        // Reset again partway through CLEAR
        for (int i = 0; i < 4; i++) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            check("midclr_init_done", 0, 32'(ido[0]), (i == 7) ? 32'd1 : 32'd0);
            check("noclear_init_done", 3, 32'(ido[3]), 32'd1);
        end
        for (int a = 0; a < 8; a++) begin
            drive(1, a, 0, 0, 0, 32'h0);
            check("reclear_zero", 0, dat[0], 32'h0);
            if (a == 1) check("noclear_kept", 3, dat[3], 32'h01010101);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
